udma_hyperbus_trans_arbiter: RTL and testbench
==============================================

// Module: udma_hyperbus_trans_arbiter
// PURPOSE
//  Round-robin scheduler sharing the single hyperbus PHY transaction port among NB_CH uDMA channels.
//  Latches the winning channel's descriptor, issues it with valid/ready, then counts 32-bit data beats to completion.
//  Produces per-channel grant and end-of-transfer pulses.
//  Sits in the sys_clk_i domain between the per-channel register files and the PHY transaction interface.
// PARAMETERS
//  NB_CH       8   number of requesting channels (>=2)
//  TRANS_SIZE  16  width of burst length field, in bytes
//  NR_CS       2   number of chip selects
// PORTS
//  sys_clk_i        in   1                 system clock
//  rst_ni           in   1                 asynchronous active-low reset
//  ch_req_i         in   NB_CH             channel has a pending transaction (level)
//  ch_clr_i         in   NB_CH             channel cancel request (pulse)
//  ch_addr_i        in   NB_CH x 32        per-channel start address
//  ch_cs_i          in   NB_CH x NR_CS     per-channel chip select (one-hot)
//  ch_write_i       in   NB_CH             per-channel write flag
//  ch_burst_i       in   NB_CH x TRANS_SIZE per-channel length, bytes
//  ch_gnt_o         out  NB_CH             1-cycle pulse: descriptor accepted by PHY
//  ch_eot_o         out  NB_CH             1-cycle pulse: transfer complete
//  trans_valid_o    out  1                 descriptor valid to PHY
//  trans_ready_i    in   1                 PHY accepts descriptor
//  trans_address_o  out  32                latched address
//  trans_cs_o       out  NR_CS             latched chip select
//  trans_write_o    out  1                 latched write flag
//  trans_burst_o    out  TRANS_SIZE        latched byte length
//  data_beat_i      in   1                 one 32-bit word moved (tx or rx handshake)
//  busy_o           out  1                 FSM not IDLE
//  active_ch_o      out  $clog2(NB_CH)     index of latched channel
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; all outputs 0; rr pointer=NB_CH-1 (ch0 highest priority next).
//  FSM IDLE -> ISSUE -> XFER -> EOT -> IDLE.
//  IDLE: if |ch_req_i, pick first requester at index >= ptr+1 (mod NB_CH); latch id, addr, cs, write, burst; ->ISSUE next cycle.
//    No requester: stay IDLE.
//  ISSUE: trans_valid_o=1, fields stable from latch.
//    On trans_ready_i: ch_gnt_o[id]=1 for one cycle; beats=(burst+3)>>2 computed in TRANS_SIZE+1 bits; ->XFER.
//  ISSUE, ch_clr_i[id]=1 without trans_ready_i: drop to IDLE; no gnt, no eot; ptr unchanged.
//    If clr and ready arrive in the same cycle, ready wins.
//  burst==0: no PHY issue; IDLE->EOT directly, ch_gnt_o and ch_eot_o pulse together.
//  XFER: data_beat_i decrements beats; beat when beats==1 -> EOT. ch_clr_i ignored (PHY cannot abort).
//    data_beat_i outside XFER ignored.
//  EOT: ch_eot_o[id]=1 one cycle; ptr<=id; ->IDLE. Minimum one IDLE cycle between transactions.
//  Latency: request to trans_valid_o = 2 cycles; last beat to ch_eot_o = 1 cycle.
//  ch_* inputs changing after latch have no effect.
//  ch_req_i dropped while not granted: simply not selected.
//  Reset mid-transfer: immediate IDLE; no eot emitted.
// STRUCTURE
//  udma_hyperbus_pkg: arb_state_e {IDLE,ISSUE,XFER,EOT}; BEAT_BYTES=4.
//  Sub-module udma_hyperbus_rr_pick: combinational rotate-priority encoder.
//    Inputs: req vector, pointer. Outputs: valid, index.
//  Descriptor latch, beat counter and FSM stay in this module.
// TESTING
//  1. Single req ch3, burst=16, ready same cycle -> valid at cycle 2; gnt[3]; 4 beats; eot[3] 1 cycle after 4th beat.
//  2. All 8 channels req continuously -> grant order 0,1,...,7,0; no channel granted twice in a row.
//  3. burst=5 -> 2 beats to eot. burst=2^16-1 -> 16384 beats, no counter overflow.
//  4. ch_clr_i[id] in ISSUE, ready low -> IDLE, no gnt/eot. clr and ready same cycle -> gnt, normal completion.
//  5. burst=0 on ch1 -> gnt[1] and eot[1] same cycle; trans_valid_o never asserted.
//  6. rst_ni low mid-XFER -> all outputs 0 asynchronously; next req from ch0 wins over ch5.

Source files
------------

// File: rtl/udma_hyperbus_trans_arbiter_pkg.sv
// udma_hyperbus_pkg: shared FSM state type and beat size for the hyperbus transaction arbiter.
// Contents: arb_state_e (IDLE, ISSUE, XFER, EOT), BEAT_BYTES (bytes moved per data beat).
package udma_hyperbus_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, XFER, EOT} arb_state_e;
   localparam int BEAT_BYTES = 4;
endpackage

// File: rtl/udma_hyperbus_trans_arbiter_if.sv
// udma_hyperbus_trans_arbiter_if: channel-side and PHY-side signal bundle of the transaction arbiter.
// Channel side: ch_req_i/ch_clr_i/ch_addr_i/ch_cs_i/ch_write_i/ch_burst_i in, ch_gnt_o/ch_eot_o out.
// PHY side: trans_valid_o + latched descriptor out, trans_ready_i and data_beat_i in.
// Status: busy_o, active_ch_o. Modport master is the arbiter, slave is its environment.
interface udma_hyperbus_trans_arbiter_if #(
   parameter int NB_CH      = 8,
   parameter int TRANS_SIZE = 16,
   parameter int NR_CS      = 2
);
   logic [NB_CH-1:0]                 ch_req_i;
   logic [NB_CH-1:0]                 ch_clr_i;
   logic [NB_CH-1:0][31:0]           ch_addr_i;
   logic [NB_CH-1:0][NR_CS-1:0]      ch_cs_i;
   logic [NB_CH-1:0]                 ch_write_i;
   logic [NB_CH-1:0][TRANS_SIZE-1:0] ch_burst_i;
   logic [NB_CH-1:0]                 ch_gnt_o;
   logic [NB_CH-1:0]                 ch_eot_o;
   logic                             trans_valid_o;
   logic                             trans_ready_i;
   logic [31:0]                      trans_address_o;
   logic [NR_CS-1:0]                 trans_cs_o;
   logic                             trans_write_o;
   logic [TRANS_SIZE-1:0]            trans_burst_o;
   logic                             data_beat_i;
   logic                             busy_o;
   logic [$clog2(NB_CH)-1:0]         active_ch_o;
   modport master (
      input  ch_req_i, ch_clr_i, ch_addr_i, ch_cs_i, ch_write_i, ch_burst_i, trans_ready_i, data_beat_i,
      output ch_gnt_o, ch_eot_o, trans_valid_o, trans_address_o, trans_cs_o, trans_write_o, trans_burst_o,
             busy_o, active_ch_o
   );
   modport slave (
      output ch_req_i, ch_clr_i, ch_addr_i, ch_cs_i, ch_write_i, ch_burst_i, trans_ready_i, data_beat_i,
      input  ch_gnt_o, ch_eot_o, trans_valid_o, trans_address_o, trans_cs_o, trans_write_o, trans_burst_o,
             busy_o, active_ch_o
   );
endinterface

// File: rtl/udma_hyperbus_trans_arbiter_rr_pick.sv
// udma_hyperbus_rr_pick: combinational rotating-priority encoder.
// Ports: req (request vector), ptr (last served index), valid (any request), index (first requester after ptr).
module udma_hyperbus_rr_pick #(
   parameter int NB_CH = 8
) (
   input  logic [NB_CH-1:0]         req,
   input  logic [$clog2(NB_CH)-1:0] ptr,
   output logic                     valid,
   output logic [$clog2(NB_CH)-1:0] index
);
   logic [$clog2(NB_CH)-1:0] j;
   // Scan from the farthest offset down to ptr+1 so the nearest requester is the last one written.
   always_comb begin
      valid = 1'b0;
      index = '0;
      j     = '0;
      for (int i = NB_CH; i >= 1; i--) begin
         j = $clog2(NB_CH)'((int'(ptr) + i) % NB_CH);
         if (req[j]) begin
            valid = 1'b1;
            index = j;
         end
      end
   end
endmodule

// File: rtl/udma_hyperbus_trans_arbiter.sv
// udma_hyperbus_trans_arbiter: round-robin scheduler sharing one hyperbus PHY transaction port among NB_CH channels.
// Ports: sys_clk_i (clock), rst_ni (async active-low reset),
//        bus (master modport: channel descriptors/requests in, PHY descriptor handshake out, gnt/eot pulses, status).
module udma_hyperbus_trans_arbiter
   import udma_hyperbus_pkg::*;
#(
   parameter int NB_CH      = 8,
   parameter int TRANS_SIZE = 16,
   parameter int NR_CS      = 2
) (
   input logic                          sys_clk_i,
   input logic                          rst_ni,
   udma_hyperbus_trans_arbiter_if.master bus
);
   localparam int IW = $clog2(NB_CH);
   localparam int CW = TRANS_SIZE + 1;
   arb_state_e            state_q, state_d;
   logic [IW-1:0]         ptr_q, id_q, pick_idx;
   logic                  pick_valid, zero_q, fire;
   logic [31:0]           addr_q;
   logic [NR_CS-1:0]      cs_q;
   logic                  write_q;
   logic [TRANS_SIZE-1:0] burst_q;
   logic [CW-1:0]         beats_q, beats_init;

   udma_hyperbus_rr_pick #(.NB_CH(NB_CH)) u_pick (
      .req   (bus.ch_req_i),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // One extra bit so a full-range byte count rounds up to whole words without wrapping.
   assign beats_init = (CW'(burst_q) + CW'(BEAT_BYTES - 1)) >> $clog2(BEAT_BYTES);

   // A zero-length descriptor skips the PHY and is granted in EOT together with its eot.
   assign fire                = (state_q == ISSUE && bus.trans_ready_i) || (state_q == EOT && zero_q);
   assign bus.ch_gnt_o        = NB_CH'(fire) << id_q;
   assign bus.ch_eot_o        = NB_CH'(state_q == EOT) << id_q;
   assign bus.trans_valid_o   = state_q == ISSUE;
   assign bus.trans_address_o = addr_q;
   assign bus.trans_cs_o      = cs_q;
   assign bus.trans_write_o   = write_q;
   assign bus.trans_burst_o   = burst_q;
   assign bus.busy_o          = state_q != IDLE;
   assign bus.active_ch_o     = id_q;

   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;

   // Ready beats a same-cycle cancel; once the PHY has the descriptor the transfer cannot be aborted.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = !pick_valid ? IDLE : (bus.ch_burst_i[pick_idx] == '0 ? EOT : ISSUE);
         ISSUE:   state_d = bus.trans_ready_i ? XFER : (bus.ch_clr_i[id_q] ? IDLE : ISSUE);
         XFER:    state_d = (bus.data_beat_i && beats_q == CW'(1)) ? EOT : XFER;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i or negedge rst_ni)
      if (!rst_ni) begin
         ptr_q   <= IW'(NB_CH - 1);
         id_q    <= '0;
         zero_q  <= 1'b0;
         addr_q  <= '0;
         cs_q    <= '0;
         write_q <= 1'b0;
         burst_q <= '0;
         beats_q <= '0;
      end else begin
         if (state_q == IDLE && pick_valid) begin
            id_q    <= pick_idx;
            addr_q  <= bus.ch_addr_i[pick_idx];
            cs_q    <= bus.ch_cs_i[pick_idx];
            write_q <= bus.ch_write_i[pick_idx];
            burst_q <= bus.ch_burst_i[pick_idx];
            zero_q  <= bus.ch_burst_i[pick_idx] == '0;
         end
         if (state_q == ISSUE) beats_q <= beats_init;
         else if (state_q == XFER && bus.data_beat_i) beats_q <= beats_q - CW'(1);
         if (state_q == EOT) ptr_q <= id_q;
      end
endmodule

// File: tb/tb_udma_hyperbus_trans_arbiter.sv
// tb_udma_hyperbus_trans_arbiter: directed self-checking bench for the hyperbus transaction arbiter.
module tb_udma_hyperbus_trans_arbiter;
   logic clk = 1'b0;
   logic rst_ni;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   udma_hyperbus_trans_arbiter_if bus ();

   udma_hyperbus_trans_arbiter dut (
      .sys_clk_i (clk),
      .rst_ni    (rst_ni),
      .bus       (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input logic [2:0] c, input logic [31:0] a, input logic [1:0] cs, input logic w,
                         input logic [15:0] b);
      bus.ch_addr_i[c]  = a;
      bus.ch_cs_i[c]    = cs;
      bus.ch_write_i[c] = w;
      bus.ch_burst_i[c] = b;
   endtask

   // Waits (bounded) for a descriptor, accepts it, supplies nbeats beats and records what was seen.
   task automatic run_xact(input int nbeats, output logic [7:0] gnt, output logic [7:0] eot,
                           output logic [7:0] early, output int ach, output logic [15:0] burst,
                           output logic busy_after);
      gnt = '0; eot = '0; early = '0; ach = -1; burst = '0; busy_after = 1'b1;
      for (int t = 0; t < 8 && bus.trans_valid_o !== 1'b1; t++) step();
      if (bus.trans_valid_o !== 1'b1) return;
      ach   = int'(bus.active_ch_o);
      burst = bus.trans_burst_o;
      bus.trans_ready_i = 1'b1;
      #1;
      gnt = bus.ch_gnt_o;
      step();
      bus.trans_ready_i = 1'b0;
      bus.data_beat_i   = 1'b1;
      for (int b = 1; b < nbeats; b++) begin
         step();
         early |= bus.ch_eot_o;
      end
      step();
      bus.data_beat_i = 1'b0;
      #1;
      eot = bus.ch_eot_o;
      step();
      busy_after = bus.busy_o;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #3;
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
      checks++; if (bus.trans_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.trans_valid_o); end
      checks++; if (bus.ch_gnt_o !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h want 00", bus.ch_gnt_o); end
      checks++; if (bus.ch_eot_o !== 8'h00) begin errors++; $display("FAIL reset_eot: got %h want 00", bus.ch_eot_o); end
      checks++; if (bus.trans_address_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.trans_address_o); end
      step();
      rst_ni = 1'b1;
   endtask

   // Fresh reset pointer is NB_CH-1, so with everyone requesting the order is 0..7 then 0 again.
   task automatic test_round_robin();
      logic [7:0] gnt, eot, early, want;
      logic [15:0] burst;
      logic busy_after;
      int ach, exp_ch;
      for (int c = 0; c < 8; c++) set_ch(3'(c), 32'h0100_0000 + 32'(c), 2'b01, 1'b0, 16'd4);
      bus.ch_req_i = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         exp_ch = k % 8;
         want   = 8'h01 << exp_ch;
         run_xact(1, gnt, eot, early, ach, burst, busy_after);
         checks++; if (ach !== exp_ch) begin errors++; $display("FAIL rr_active[%0d]: got %0d want %0d", k, ach, exp_ch); end
         checks++; if (gnt !== want) begin errors++; $display("FAIL rr_gnt[%0d]: got %h want %h", k, gnt, want); end
         checks++; if (eot !== want) begin errors++; $display("FAIL rr_eot[%0d]: got %h want %h", k, eot, want); end
         checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL rr_idle_gap[%0d]: got %b want 0", k, busy_after); end
      end
      bus.ch_req_i = 8'h00;
   endtask

   task automatic test_single();
      set_ch(3'd3, 32'h1000_0030, 2'b10, 1'b1, 16'd16);
      bus.ch_req_i      = 8'h08;
      bus.trans_ready_i = 1'b1;
      #1;
      checks++; if (bus.trans_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_c1: got %b want 0", bus.trans_valid_o); end
      step();
      checks++; if (bus.trans_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_c2: got %b want 1", bus.trans_valid_o); end
      checks++; if (bus.trans_address_o !== 32'h1000_0030) begin errors++; $display("FAIL single_addr: got %h want 10000030", bus.trans_address_o); end
      checks++; if (bus.trans_cs_o !== 2'b10) begin errors++; $display("FAIL single_cs: got %b want 10", bus.trans_cs_o); end
      checks++; if (bus.trans_write_o !== 1'b1) begin errors++; $display("FAIL single_write: got %b want 1", bus.trans_write_o); end
      checks++; if (bus.trans_burst_o !== 16'd16) begin errors++; $display("FAIL single_burst: got %0d want 16", bus.trans_burst_o); end
      checks++; if (bus.active_ch_o !== 3'd3) begin errors++; $display("FAIL single_active: got %0d want 3", bus.active_ch_o); end
      checks++; if (bus.ch_gnt_o !== 8'h08) begin errors++; $display("FAIL single_gnt: got %h want 08", bus.ch_gnt_o); end
      bus.ch_addr_i[3] = 32'hDEAD_BEEF;
      bus.ch_req_i     = 8'h00;
      step();
      bus.trans_ready_i = 1'b0;
      #1;
      checks++; if (bus.trans_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_xfer: got %b want 0", bus.trans_valid_o); end
      checks++; if (bus.ch_gnt_o !== 8'h00) begin errors++; $display("FAIL single_gnt_once: got %h want 00", bus.ch_gnt_o); end
      checks++; if (bus.trans_address_o !== 32'h1000_0030) begin errors++; $display("FAIL single_addr_held: got %h want 10000030", bus.trans_address_o); end
      bus.data_beat_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) begin
            checks++; if (bus.ch_eot_o !== 8'h00) begin errors++; $display("FAIL single_eot_early[%0d]: got %h want 00", k, bus.ch_eot_o); end
         end else begin
            checks++; if (bus.ch_eot_o !== 8'h08) begin errors++; $display("FAIL single_eot: got %h want 08", bus.ch_eot_o); end
         end
      end
      bus.data_beat_i = 1'b0;
      step();
      checks++; if (bus.ch_eot_o !== 8'h00) begin errors++; $display("FAIL single_eot_pulse: got %h want 00", bus.ch_eot_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL single_idle: got %b want 0", bus.busy_o); end
   endtask

   task automatic test_burst_len();
      logic [7:0] gnt, eot, early;
      logic [15:0] burst;
      logic busy_after;
      int ach;
      set_ch(3'd2, 32'h2000_0000, 2'b01, 1'b0, 16'd5);
      bus.ch_req_i = 8'h04;
      run_xact(2, gnt, eot, early, ach, burst, busy_after);
      checks++; if (gnt !== 8'h04) begin errors++; $display("FAIL b5_gnt: got %h want 04", gnt); end
      checks++; if (early !== 8'h00) begin errors++; $display("FAIL b5_early_eot: got %h want 00", early); end
      checks++; if (eot !== 8'h04) begin errors++; $display("FAIL b5_eot: got %h want 04", eot); end
      bus.ch_burst_i[2] = 16'hFFFF;
      run_xact(16384, gnt, eot, early, ach, burst, busy_after);
      bus.ch_req_i = 8'h00;
      checks++; if (burst !== 16'hFFFF) begin errors++; $display("FAIL bmax_burst: got %h want ffff", burst); end
      checks++; if (early !== 8'h00) begin errors++; $display("FAIL bmax_early_eot: got %h want 00", early); end
      checks++; if (eot !== 8'h04) begin errors++; $display("FAIL bmax_eot: got %h want 04", eot); end
   endtask

   task automatic test_clear();
      set_ch(3'd4, 32'h4000_0000, 2'b01, 1'b1, 16'd8);
      bus.ch_req_i = 8'h10;
      step();
      checks++; if (bus.trans_valid_o !== 1'b1) begin errors++; $display("FAIL clr_valid: got %b want 1", bus.trans_valid_o); end
      bus.ch_clr_i = 8'h10;
      #1;
      checks++; if (bus.ch_gnt_o !== 8'h00) begin errors++; $display("FAIL clr_no_gnt: got %h want 00", bus.ch_gnt_o); end
      step();
      bus.ch_clr_i = 8'h00;
      bus.ch_req_i = 8'h00;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL clr_idle: got %b want 0", bus.busy_o); end
      checks++; if (bus.ch_eot_o !== 8'h00) begin errors++; $display("FAIL clr_no_eot: got %h want 00", bus.ch_eot_o); end
      bus.ch_req_i = 8'h10;
      step();
      bus.ch_clr_i      = 8'h10;
      bus.trans_ready_i = 1'b1;
      #1;
      checks++; if (bus.ch_gnt_o !== 8'h10) begin errors++; $display("FAIL clr_ready_gnt: got %h want 10", bus.ch_gnt_o); end
      step();
      bus.trans_ready_i = 1'b0;
      bus.data_beat_i   = 1'b1;
      step();
      bus.ch_clr_i = 8'h00;
      #1;
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL clr_xfer_ignored: got %b want 1", bus.busy_o); end
      step();
      bus.data_beat_i = 1'b0;
      bus.ch_req_i    = 8'h00;
      #1;
      checks++; if (bus.ch_eot_o !== 8'h10) begin errors++; $display("FAIL clr_ready_eot: got %h want 10", bus.ch_eot_o); end
      step();
   endtask

   task automatic test_zero_burst();
      set_ch(3'd1, 32'h1100_0000, 2'b01, 1'b0, 16'd0);
      bus.ch_req_i = 8'h02;
      #1;
      checks++; if (bus.trans_valid_o !== 1'b0) begin errors++; $display("FAIL zero_valid_idle: got %b want 0", bus.trans_valid_o); end
      step();
      checks++; if (bus.ch_gnt_o !== 8'h02) begin errors++; $display("FAIL zero_gnt: got %h want 02", bus.ch_gnt_o); end
      checks++; if (bus.ch_eot_o !== 8'h02) begin errors++; $display("FAIL zero_eot: got %h want 02", bus.ch_eot_o); end
      checks++; if (bus.trans_valid_o !== 1'b0) begin errors++; $display("FAIL zero_valid_eot: got %b want 0", bus.trans_valid_o); end
      bus.ch_req_i = 8'h00;
      step();
      checks++; if (bus.ch_gnt_o !== 8'h00) begin errors++; $display("FAIL zero_gnt_pulse: got %h want 00", bus.ch_gnt_o); end
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL zero_idle: got %b want 0", bus.busy_o); end
   endtask

   // Pointer sits at 1 before reset, so ch0 beating ch5 afterwards shows the pointer was reinitialised.
   task automatic test_reset_mid();
      set_ch(3'd5, 32'h5000_0000, 2'b01, 1'b0, 16'd16);
      set_ch(3'd0, 32'h0000_0A00, 2'b10, 1'b1, 16'd4);
      bus.ch_req_i = 8'h20;
      step();
      bus.trans_ready_i = 1'b1;
      step();
      bus.trans_ready_i = 1'b0;
      bus.data_beat_i   = 1'b1;
      step();
      bus.data_beat_i = 1'b0;
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", bus.busy_o); end
      rst_ni = 1'b0;
      #1;
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy_o); end
      checks++; if (bus.active_ch_o !== 3'd0) begin errors++; $display("FAIL mid_rst_active: got %0d want 0", bus.active_ch_o); end
      checks++; if (bus.trans_address_o !== 32'h0) begin errors++; $display("FAIL mid_rst_addr: got %h want 0", bus.trans_address_o); end
      step();
      step();
      checks++; if (bus.ch_eot_o !== 8'h00) begin errors++; $display("FAIL mid_rst_no_eot: got %h want 00", bus.ch_eot_o); end
      rst_ni       = 1'b1;
      bus.ch_req_i = 8'h21;
      step();
      checks++; if (bus.active_ch_o !== 3'd0) begin errors++; $display("FAIL mid_next_active: got %0d want 0", bus.active_ch_o); end
      checks++; if (bus.trans_address_o !== 32'h0000_0A00) begin errors++; $display("FAIL mid_next_addr: got %h want 00000a00", bus.trans_address_o); end
      bus.trans_ready_i = 1'b1;
      #1;
      checks++; if (bus.ch_gnt_o !== 8'h01) begin errors++; $display("FAIL mid_next_gnt: got %h want 01", bus.ch_gnt_o); end
      step();
      bus.trans_ready_i = 1'b0;
      bus.ch_req_i      = 8'h00;
      bus.data_beat_i   = 1'b1;
      step();
      bus.data_beat_i = 1'b0;
      #1;
      checks++; if (bus.ch_eot_o !== 8'h01) begin errors++; $display("FAIL mid_next_eot: got %h want 01", bus.ch_eot_o); end
      step();
   endtask

   initial begin
      bus.ch_req_i      = '0;
      bus.ch_clr_i      = '0;
      bus.ch_addr_i     = '0;
      bus.ch_cs_i       = '0;
      bus.ch_write_i    = '0;
      bus.ch_burst_i    = '0;
      bus.trans_ready_i = 1'b0;
      bus.data_beat_i   = 1'b0;
      test_reset();
      test_round_robin();
      test_single();
      test_burst_len();
      test_clear();
      test_zero_burst();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
